// File: rtl/cu_bubble_if.sv
// Handshake/control bundle between the control unit and the bubble stage.
// The master modport is the control-unit side. The slave modport is the stage.
interface cu_bubble_if #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 2
);
    logic [CTRL_W-1:0] ctrl_in;
    logic              valid_in;
    logic              cond_pass;
    logic              stall;
    logic              flush;
    logic              bubble_req;
    logic [CNT_W-1:0]  bubble_len;
    logic [CTRL_W-1:0] ctrl_out;
    logic              valid_out;
    logic              ready_out;
    logic [15:0]       bubble_total;

    modport master (
        output ctrl_in, valid_in, cond_pass, stall, flush, bubble_req, bubble_len,
        input  ctrl_out, valid_out, ready_out, bubble_total
    );

    modport slave (
        input  ctrl_in, valid_in, cond_pass, stall, flush, bubble_req, bubble_len,
        output ctrl_out, valid_out, ready_out, bubble_total
    );
endinterface

// File: rtl/cu_bubble_stage.sv
// Registered control-bundle stage with NOP injection, stall hold and a bubble-run sequencer.
// Optional bubble statistics counter is enabled by defining CU_BUBBLE_STATS_EN.
module cu_bubble_stage #(
    parameter int                CTRL_W       = 8,
    parameter logic [CTRL_W-1:0] BUBBLE_VALUE = {CTRL_W{1'b0}},
    parameter int                MAX_BUBBLES  = 3,
    parameter int                CNT_W        = 2
) (
    input  logic  clk,
    input  logic  reset,
    cu_bubble_if.slave bus
);
    localparam logic [0:0]       ST_RUN    = 1'b0;
    localparam logic [0:0]       ST_BUBBLE = 1'b1;
    localparam logic [CNT_W-1:0] MAX_B     = CNT_W'(MAX_BUBBLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_s;
    logic              pass_s;
    logic              hold_s;
    logic [CNT_W-1:0]  eff_s;

    assign req_s  = bus.bubble_req && (bus.bubble_len != CNT_ZERO);
    assign pass_s = bus.valid_in && bus.cond_pass;
    assign hold_s = bus.stall && !bus.flush;
    assign eff_s  = (bus.bubble_len > MAX_B) ? MAX_B : bus.bubble_len;

    // Next-state selection: flush beats stall, stall beats the sequencer.
    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            ctrl_d  = BUBBLE_VALUE;
            valid_d = 1'b0;
            state_d = ST_RUN;
            cnt_d   = CNT_ZERO;
        end else if (bus.stall) begin
            ctrl_d  = ctrl_q;
            valid_d = valid_q;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (req_s) begin
                        ctrl_d  = BUBBLE_VALUE;
                        valid_d = 1'b0;
                        if (eff_s > CNT_ONE) begin
                            cnt_d   = eff_s - CNT_ONE;
                            state_d = ST_BUBBLE;
                        end else begin
                            cnt_d   = CNT_ZERO;
                            state_d = ST_RUN;
                        end
                    end else begin
                        ctrl_d  = pass_s ? bus.ctrl_in : BUBBLE_VALUE;
                        valid_d = pass_s;
                    end
                end
                ST_BUBBLE: begin
                    ctrl_d  = BUBBLE_VALUE;
                    valid_d = 1'b0;
                    // A zero count here would be corrupt state; leave the run rather than wrap.
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = CNT_ZERO;
                        state_d = ST_RUN;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                        state_d = ST_BUBBLE;
                    end
                end
                default: begin
                    ctrl_d  = BUBBLE_VALUE;
                    valid_d = 1'b0;
                    cnt_d   = CNT_ZERO;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Pipeline and sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= BUBBLE_VALUE;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
            cnt_q   <= CNT_ZERO;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.ctrl_out  = ctrl_q;
    assign bus.valid_out = valid_q;
    assign bus.ready_out = !bus.stall && (state_q == ST_RUN) && !req_s;

`ifdef CU_BUBBLE_STATS_EN
    logic [15:0] total_q, total_d;
    logic        bub_wr_s;

    // An edge counts when it loads the NOP pattern with valid low; held cycles do not.
    assign bub_wr_s = !hold_s && !valid_d && (ctrl_d == BUBBLE_VALUE);

    // Saturating bubble counter, cleared only by reset.
    always_comb begin
        total_d = total_q;
        if (bub_wr_s && (total_q != 16'hFFFF)) begin
            total_d = total_q + 16'h0001;
        end else begin
            total_d = total_q;
        end
    end

    // Statistics register.
    always_ff @(posedge clk) begin
        if (reset) begin
            total_q <= 16'h0000;
        end else begin
            total_q <= total_d;
        end
    end

    assign bus.bubble_total = total_q;
`else
    assign bus.bubble_total = 16'h0000;
`endif

endmodule

// File: doc/cu_bubble_stage.md
Name: cu_bubble_stage

Overview:
- Registered successor to the combinational control-signal kill mux.
- Sits between the control unit and the ID/EX pipeline register. It carries a parametrised control bundle forward one cycle.
- On condition-fail, hazard stall, flush or a multi-cycle bubble request, it injects a programmable NOP pattern.
- Adds a bubble sequencer FSM, stall hold and an upstream ready handshake.

Parameters:
- CTRL_W, 8, width of the packed control bundle (reg_we, mem_we, mem_to_reg, alu_src, s_bit, alu_ctrl[1:0], pc_src).
- BUBBLE_VALUE, {CTRL_W{1'b0}}, pattern driven on ctrl_out for any bubble or kill.
- MAX_BUBBLES, 3, largest bubble run accepted per request; legal range 1..15.
- CNT_W, 2, bubble counter width; must satisfy 2**CNT_W > MAX_BUBBLES.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ctrl_in  input  CTRL_W  control bundle from decoder
- valid_in  input  1  ctrl_in holds a real instruction
- cond_pass  input  1  condition/S-bit select; 0 kills the instruction
- stall  input  1  hazard unit: hold current output
- flush  input  1  branch taken: kill the stage
- bubble_req  input  1  request a run of bubbles
- bubble_len  input  CNT_W  requested run length
- ctrl_out  output  CTRL_W  registered control bundle
- valid_out  output  1  registered valid
- ready_out  output  1  upstream may advance this cycle
- bubble_total  output  16  bubble statistics (see Optional Feature)

Behaviour:
- Reset values (synchronous, priority over all inputs): ctrl_out=BUBBLE_VALUE, valid_out=0, FSM=RUN, counter=0, bubble_total=0.
- Latency: one cycle, ctrl_in at edge N appears on ctrl_out after edge N.
- ready_out (combinational) = !stall && state==RUN && !(bubble_req && bubble_len!=0).
- Priority per edge: reset > flush > stall > FSM action.
- flush: ctrl_out<=BUBBLE_VALUE, valid_out<=0, FSM->RUN, counter<=0. A pending bubble run is abandoned.
- stall (no flush): ctrl_out, valid_out, FSM state and counter all hold.
- FSM states: RUN, BUBBLE.
- RUN, bubble_req=1, bubble_len!=0:
  - ctrl_out<=BUBBLE_VALUE, valid_out<=0.
  - eff = min(bubble_len, MAX_BUBBLES).
  - If eff>1, counter<=eff-1 and go to BUBBLE; otherwise stay in RUN.
  - The ctrl_in offered that cycle is not consumed (ready_out=0).
- RUN, bubble_req=0 or bubble_len=0:
  - ctrl_out <= (valid_in && cond_pass) ? ctrl_in : BUBBLE_VALUE.
  - valid_out <= valid_in && cond_pass.
- BUBBLE:
  - ctrl_out<=BUBBLE_VALUE, valid_out<=0, counter<=counter-1.
  - When counter==1 at the edge, go to RUN.
  - bubble_req is ignored (no re-arm, no extension).
- Total bubbles per accepted request = eff, excluding cycles held by stall.
- Counter never underflows; counter==0 is never observed in BUBBLE.
- Simultaneous stall and bubble_req in RUN: stall wins and the request is not latched; the requester must hold it.
- Simultaneous flush and bubble_req: flush wins and the request is dropped.

Optional Feature:
- Macro CU_BUBBLE_STATS_EN.
- Defined: bubble_total counts every edge that writes a bubble (ctrl_out<=BUBBLE_VALUE with valid_out<=0), from any cause: kill, flush, run or bubble state.
  - Held cycles under stall do not count.
  - The counter saturates at 16'hFFFF and is cleared only by reset.
- Undefined: the counter logic is removed and bubble_total is tied to 16'h0000.

Test Plan:
- Reset pass-through: assert reset 2 cycles, then valid_in=1, cond_pass=1, ctrl_in=8'hA5 -> ctrl_out=0/valid_out=0 during reset; ctrl_out=8'hA5, valid_out=1 one edge after release.
- Condition kill: ctrl_in=8'h3C, valid_in=1, cond_pass=0 -> ctrl_out=8'h00, valid_out=0, ready_out=1, bubble_total +1 (stats build).
- Bubble run: bubble_req=1, bubble_len=3 in RUN, then ctrl_in=8'h11 held -> 3 consecutive bubble edges, ready_out low for those 3 cycles, 8'h11 appears on the 4th edge. Repeat with bubble_len=3, MAX_BUBBLES=2 -> exactly 2 bubbles.
- Stall mid-run: bubble_len=3, stall=1 for 2 cycles after the first bubble -> outputs frozen, counter held, 3 bubbles total, bubble_total=3 not 5.
- Flush mid-run: bubble_len=3, flush at second bubble -> FSM returns to RUN next edge, ready_out=1, next valid ctrl_in=8'h77 passes on the following edge.
- Saturation (stats build): force 65,540 kill cycles -> bubble_total stops at 16'hFFFF; non-stats build -> bubble_total stays 0.
